// File: rtl/pipe_pkg.sv
// Shared definitions for the datapath pipeline stage registers.
package pipe_pkg;

  // Default data word width of the 16-bit datapath.
  localparam int WORD_W_DEF = 16;

  // Occupancy of a stage: nothing held, main entry held, main and skid held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;

  // Bit positions inside the decode-control vector.
  localparam int CTRL_COMPUTE     = 0;
  localparam int CTRL_COMPUTE_IMM = 1;
  localparam int CTRL_LW          = 2;
  localparam int CTRL_SW          = 3;
  localparam int CTRL_LHB         = 4;
  localparam int CTRL_LLB         = 5;
  localparam int CTRL_B           = 6;
  localparam int CTRL_BR          = 7;
  localparam int CTRL_PCS         = 8;
  localparam int CTRL_HLT         = 9;

endpackage

// File: rtl/pipe_entry.sv
// One beat of storage: data words plus decode-control bits.
// The control part can be cleared independently so a flushed entry never
// carries live decode signals; the data part is simply left stale.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = 5 * WORD_W_DEF,
  parameter int CTRL_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Load on enable; a ctrl clear wins over a simultaneous load.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      ctrl_q <= '0;
    end else begin
      if (load_i) begin
        data_q <= data_i;
      end
      if (clr_ctrl_i) begin
        ctrl_q <= '0;
      end else if (load_i) begin
        ctrl_q <= ctrl_i;
      end
    end
  end

  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/ready handshake, optional skid buffer,
// synchronous flush and a saturating back-pressure counter.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = 5,
  parameter int CTRL_W    = 10,
  parameter int SKID      = 1,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_WORDS*WORD_W-1:0] in_words,
  input  logic [CTRL_W-1:0]           in_ctrl,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_WORDS*WORD_W-1:0] out_words,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int DATA_W = NUM_WORDS * WORD_W;

  logic              valid_q;
  logic              in_xfer;
  logic              out_xfer;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CNT_W-1:0]  stall_q;

  assign out_xfer  = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_words = main_data;
  // A bubble must never present decode signals downstream.
  assign out_ctrl  = main_ctrl & {CTRL_W{valid_q}};
  assign stall_cnt = stall_q;

  generate
    if (SKID != 0) begin : g_skid
      stage_state_t      state_q, state_d;
      logic              in_ready_q;
      logic              main_load, skid_load;
      logic [DATA_W-1:0] main_din, skid_data;
      logic [CTRL_W-1:0] main_cin, skid_ctrl;

      // in_ready is a flop so upstream sees no path from out_ready.
      assign in_ready = in_ready_q;
      assign in_xfer  = in_valid && in_ready_q;

      // Next occupancy and which entry loads from where.
      always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_din  = in_words;
        main_cin  = in_ctrl;
        if (flush) begin
          state_d = ST_EMPTY;
        end else begin
          case (state_q)
            ST_EMPTY: begin
              if (in_xfer) begin
                state_d   = ST_ONE;
                main_load = 1'b1;
              end
            end
            ST_ONE: begin
              if (in_xfer && !out_xfer) begin
                state_d   = ST_TWO;
                skid_load = 1'b1;
              end else if (in_xfer) begin
                main_load = 1'b1;
              end else if (out_xfer) begin
                state_d = ST_EMPTY;
              end
            end
            ST_TWO: begin
              if (out_xfer) begin
                state_d   = ST_ONE;
                main_load = 1'b1;
                main_din  = skid_data;
                main_cin  = skid_ctrl;
              end
            end
            default: state_d = ST_EMPTY;
          endcase
        end
      end

      // Occupancy register with valid and ready decoded one cycle ahead.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_q    <= ST_EMPTY;
          valid_q    <= 1'b0;
          in_ready_q <= 1'b1;
        end else begin
          state_q    <= state_d;
          valid_q    <= (state_d != ST_EMPTY);
          in_ready_q <= (state_d != ST_TWO);
        end
      end

      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk        (clk),
        .rst        (rst),
        .load_i     (main_load),
        .clr_ctrl_i (flush),
        .data_i     (main_din),
        .ctrl_i     (main_cin),
        .data_o     (main_data),
        .ctrl_o     (main_ctrl)
      );

      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load_i     (skid_load),
        .clr_ctrl_i (flush),
        .data_i     (in_words),
        .ctrl_i     (in_ctrl),
        .data_o     (skid_data),
        .ctrl_o     (skid_ctrl)
      );
    end else begin : g_single
      // Accept whenever the single entry is free or is leaving this cycle.
      assign in_ready = !valid_q || out_ready;
      assign in_xfer  = in_valid && in_ready;

      // Valid flag of the single entry.
      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (in_xfer) begin
          valid_q <= 1'b1;
        end else if (out_xfer) begin
          valid_q <= 1'b0;
        end
      end

      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk        (clk),
        .rst        (rst),
        .load_i     (in_xfer && !flush),
        .clr_ctrl_i (flush),
        .data_i     (in_words),
        .ctrl_i     (in_ctrl),
        .data_o     (main_data),
        .ctrl_o     (main_ctrl)
      );
    end
  endgenerate

  // Count cycles the head beat is blocked; saturate, ignore flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench: accepted beats are queued, a monitor pops them as the
// stage delivers. One skid instance (4-bit counter) and one single-entry one.
module tb_pipe_stage;

  localparam int WW = 16;
  localparam int NW = 5;
  localparam int CW = 10;
  localparam int DW = NW * WW;

  typedef struct packed {
    logic [DW-1:0] w;
    logic [CW-1:0] c;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          a_flush, a_valid, a_oready, a_iready, a_ovalid;
  logic [DW-1:0] a_words, a_owords;
  logic [CW-1:0] a_ctrl, a_octrl;
  logic [3:0]    a_stall;

  logic          b_flush, b_valid, b_oready, b_iready, b_ovalid;
  logic [DW-1:0] b_words, b_owords;
  logic [CW-1:0] b_ctrl, b_octrl;
  logic [15:0]   b_stall;

  pipe_stage #(.WORD_W(WW), .NUM_WORDS(NW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_valid), .in_ready(a_iready),
    .in_words(a_words), .in_ctrl(a_ctrl), .out_valid(a_ovalid), .out_ready(a_oready),
    .out_words(a_owords), .out_ctrl(a_octrl), .stall_cnt(a_stall)
  );

  pipe_stage #(.WORD_W(WW), .NUM_WORDS(NW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_valid), .in_ready(b_iready),
    .in_words(b_words), .in_ctrl(b_ctrl), .out_valid(b_ovalid), .out_ready(b_oready),
    .out_words(b_owords), .out_ctrl(b_octrl), .stall_cnt(b_stall)
  );

  int errors = 0;
  int checks = 0;
  beat_t qa[$];
  beat_t qb[$];

  function automatic logic [DW-1:0] mkw(input logic [15:0] v);
    logic [DW-1:0] r;
    for (int k = 0; k < NW; k++) r[k*WW +: WW] = v + 16'(k << 12);
    return r;
  endfunction

  function automatic logic [CW-1:0] mkc(input logic [15:0] v);
    return v[9:0] ^ 10'h155;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [15:0] v);
    a_valid = 1'b1;
    a_words = mkw(v);
    a_ctrl  = mkc(v);
  endtask

  // Record accepted beats at the edge where they transfer in.
  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_flush) qa.delete();
      else if (a_valid && a_iready) qa.push_back('{w: a_words, c: a_ctrl});
      if (b_flush) qb.delete();
      else if (b_valid && b_iready) qb.push_back('{w: b_words, c: b_ctrl});
    end
  end

  // Compare delivered beats against the scoreboard; bubbles must carry no ctrl.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (a_ovalid && a_oready) begin
        if (qa.size() == 0) chk("a_unexpected_beat", a_owords, '0);
        else begin
          e = qa.pop_front();
          chk("a_beat", {a_octrl, a_owords}, {e.c, e.w});
        end
      end else if (!a_ovalid) chk("a_bubble_ctrl", a_octrl, '0);
      if (b_ovalid && b_oready) begin
        if (qb.size() == 0) chk("b_unexpected_beat", b_owords, '0);
        else begin
          e = qb.pop_front();
          chk("b_beat", {b_octrl, b_owords}, {e.c, e.w});
        end
      end else if (!b_ovalid) chk("b_bubble_ctrl", b_octrl, '0);
    end
  end

  bit pat [12] = '{1, 0, 1, 0, 0, 1, 1, 0, 1, 1, 1, 0};

  initial begin
    int nxt;
    int bstalls;
    logic acc;

    // Reset held two cycles with a beat offered upstream.
    rst = 1'b1;
    a_flush = 1'b0; a_oready = 1'b0; a_valid = 1'b1; a_words = '1; a_ctrl = '1;
    b_flush = 1'b0; b_oready = 1'b0; b_valid = 1'b1; b_words = '1; b_ctrl = '1;
    tick; tick;
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    chk("rst_out_valid", a_ovalid, 0);
    chk("rst_out_ctrl", a_octrl, 0);
    chk("rst_out_words", a_owords, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_in_ready", a_iready, 1);
    chk("rst_b_in_ready", b_iready, 1);

    // Streaming: one beat per cycle, one-cycle latency, no gaps.
    a_oready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_a(16'(i));
      tick;
      chk("stream_valid", a_ovalid, 1);
      chk("stream_word0", a_owords[15:0], 16'(i));
    end
    a_valid = 1'b0;
    tick;
    chk("stream_drained", a_ovalid, 0);
    chk("stream_stall", a_stall, 0);

    // Back-pressure: two accepted, third held upstream.
    a_oready = 1'b0;
    send_a(16'h1111); tick;
    chk("bp_ready_one", a_iready, 1);
    send_a(16'h2222); tick;
    chk("bp_ready_two", a_iready, 0);
    chk("bp_stall1", a_stall, 1);
    send_a(16'h3333); tick; tick;
    chk("bp_ready_held", a_iready, 0);
    chk("bp_head", a_owords[15:0], 16'h1111);
    chk("bp_stall3", a_stall, 3);
    a_oready = 1'b1; tick;
    chk("bp_ready_back", a_iready, 1);
    chk("bp_stall_hold", a_stall, 3);
    tick;
    a_valid = 1'b0; tick;
    chk("bp_drained", a_ovalid, 0);

    // Flush from TWO while a beat is offered.
    a_oready = 1'b0;
    send_a(16'hAAAA); tick;
    send_a(16'hBBBB); tick;
    chk("fl_full", a_iready, 0);
    a_flush = 1'b1; send_a(16'hBEEF); tick;
    a_flush = 1'b0; a_valid = 1'b0;
    chk("fl_valid", a_ovalid, 0);
    chk("fl_ctrl", a_octrl, 0);
    chk("fl_ready", a_iready, 1);
    tick;
    chk("fl_stall", a_stall, 5);

    // Flush from ONE with in_ready high: incoming beat discarded.
    send_a(16'hCCCC); tick;
    a_flush = 1'b1; send_a(16'hDDDD); tick;
    a_flush = 1'b0; a_valid = 1'b0;
    chk("fl1_valid", a_ovalid, 0);
    tick;
    chk("fl1_still_empty", a_ovalid, 0);
    chk("fl1_stall", a_stall, 6);

    // Saturation of the 4-bit counter, and flush leaves it alone.
    send_a(16'hEEEE); tick;
    a_valid = 1'b0;
    repeat (20) tick;
    chk("sat_stall", a_stall, 15);
    a_flush = 1'b1; tick;
    a_flush = 1'b0;
    chk("sat_after_flush", a_stall, 15);
    chk("sat_flushed", a_ovalid, 0);

    // Reset mid-operation drops the held beat.
    send_a(16'h5555); tick;
    a_valid = 1'b0; rst = 1'b1; tick;
    rst = 1'b0;
    chk("mid_rst_valid", a_ovalid, 0);
    chk("mid_rst_stall", a_stall, 0);
    chk("mid_rst_words", a_owords, 0);
    chk("mid_rst_ready", a_iready, 1);

    // Single-entry mode: continuous input, out_ready toggling.
    nxt = 0;
    bstalls = 0;
    for (int c = 0; c < 12; c++) begin
      b_valid  = 1'b1;
      b_words  = mkw(16'h0100 + 16'(nxt));
      b_ctrl   = mkc(16'h0100 + 16'(nxt));
      b_oready = pat[c];
      #1;
      if (b_ovalid) chk("b_ready_mirror", b_iready, pat[c]);
      else chk("b_ready_empty", b_iready, 1);
      if (b_ovalid && !pat[c]) bstalls++;
      acc = b_iready;
      tick;
      if (acc) nxt++;
    end
    b_valid = 1'b0; b_oready = 1'b1;
    tick; tick;
    chk("b_drained", b_ovalid, 0);
    chk("b_stall", b_stall, 16'(bstalls));
    chk("b_stall_five", b_stall, 5);

    chk("a_queue_empty", DW'(qa.size()), 0);
    chk("b_queue_empty", DW'(qb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register for the 16-bit processor datapath: carries N data words (pc, alu result, instruction, operands) plus a decode-control vector from one stage to the next. Adds a valid/ready handshake, an optional two-entry skid buffer for full throughput under back-pressure, a synchronous flush for bubble insertion on taken branches, and a saturating stall counter. Instantiated between every adjacent pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- WORD_W, 16, width of each data word
- NUM_WORDS, 5, number of data words carried
- CTRL_W, 10, width of decode-control vector
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- CNT_W, 16, stall counter width

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held and incoming beats this cycle
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage accepts a beat this cycle
- in_words  in  NUM_WORDS*WORD_W  packed data, word 0 in LSBs
- in_ctrl  in  CTRL_W  decode-control bits
- out_valid  out  1  downstream beat present
- out_ready  in  1  downstream accepts
- out_words  out  NUM_WORDS*WORD_W  data of head beat
- out_ctrl  out  CTRL_W  control of head beat; all-zero when out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- SKID=1 states: EMPTY (no entries), ONE (main valid), TWO (main + skid valid).
  - EMPTY: in xfer -> ONE (load main).
  - ONE: in only -> TWO (load skid); out only -> EMPTY; both -> ONE (main reloaded from input).
  - TWO: out xfer -> ONE (main <= skid); no input accepted.
  - in_ready is a register: 1 in EMPTY/ONE, 0 in TWO.
- SKID=0: single entry; in_ready = !out_valid || out_ready (combinational); in xfer loads entry, out xfer without in xfer clears valid.
- Beat order strictly FIFO; no beat duplicated or dropped except by flush.
- flush: next state EMPTY, all stored ctrl cleared to 0, incoming beat in that cycle discarded even if in_ready=1. Data words need not be cleared. flush overrides simultaneous in/out transfers (an out transfer in the flush cycle still counts as delivered downstream).
- out_ctrl gated to 0 whenever out_valid=0, so a bubble never asserts decode signals (D_hlt, D_sw, etc.).
- stall_cnt increments when out_valid && !out_ready, holds at 2^CNT_W-1, unaffected by flush, cleared only by rst.

## Timing
- Latency: input beat visible at outputs one cycle after acceptance.
- Throughput: one beat/cycle sustained with out_ready=1 in both modes.
- Reset (rst=1 at edge): out_valid=0, out_words=0, out_ctrl=0, stall_cnt=0, state EMPTY, in_ready=1 (SKID=1) from the following cycle; rst dominates flush and all transfers.
- Reset mid-operation discards all held beats; no partial state retained.
- SKID=1: in_ready has no combinational path from out_ready.
- out_valid, out_words, out_ctrl driven directly from registers (no logic from in_* ports).

## Structure
- Shared package pipe_pkg: WORD_W default, stage state typedef (EMPTY/ONE/TWO), control-bit index constants (CTRL_COMPUTE, CTRL_COMPUTE_IMM, CTRL_LW, CTRL_SW, CTRL_LHB, CTRL_LLB, CTRL_B, CTRL_BR, CTRL_PCS, CTRL_HLT = 0..9).
- One sub-module: pipe_entry — a register of NUM_WORDS*WORD_W+CTRL_W bits with load enable, synchronous ctrl clear, and rst; instantiated once (SKID=0) or twice (SKID=1).

## Test plan
- Reset: rst held 2 cycles with in_valid=1, in_words=all 0xFFFF -> out_valid=0, out_ctrl=0, stall_cnt=0, in_ready=1 after release.
- Streaming: 8 beats word0=0x0000..0x0007, out_ready=1 -> out_words word0 = 0..7 on consecutive cycles, 1-cycle latency, no gaps.
- Back-pressure (SKID=1): send 0x1111, 0x2222, 0x3333 with out_ready=0 -> in_ready falls after 2 accepted, 0x3333 held upstream; release out_ready -> outputs 0x1111, 0x2222, 0x3333 in order; stall_cnt equals stalled cycles.
- Flush: state TWO, assert flush with in_valid=1 word0=0xBEEF -> next cycle out_valid=0, out_ctrl=0, 0xBEEF never appears at output.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15; flush does not clear it.
- SKID=0 mode: out_ready toggling 1,0,1 with continuous input -> in_ready mirrors out_ready while full; order preserved, no loss.
